iterative_alu: RTL and testbench

- Parametrised-width execute unit: RV32I ALU operation set plus the M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Single-cycle ops return a registered result one cycle after accept. MUL/DIV run iteratively over XLEN cycles.
- Valid/ready handshake on input and output. Sits in the EX stage; the hazard unit stalls the pipe while in_ready is low.

---
 rtl/alu_pkg.sv | 55 +++++
 rtl/iterative_alu_if.sv | 26 ++
 rtl/iter_divider.sv | 55 +++++
 rtl/iterative_alu.sv | 164 ++++++++++++++++
 tb/tb_iterative_alu.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/state types and opcode-class helpers for the iterative execute unit.
package alu_pkg;

   typedef enum logic [4:0] {
      OP_ADD    = 5'h00,
      OP_SUB    = 5'h01,
      OP_AND    = 5'h02,
      OP_OR     = 5'h03,
      OP_XOR    = 5'h04,
      OP_SLT    = 5'h05,
      OP_SLTU   = 5'h06,
      OP_SLL    = 5'h07,
      OP_SRL    = 5'h08,
      OP_SRA    = 5'h09,
      OP_ABJ    = 5'h0A,
      OP_NOP    = 5'h0F,
      OP_MUL    = 5'h10,
      OP_MULH   = 5'h11,
      OP_MULHSU = 5'h12,
      OP_MULHU  = 5'h13,
      OP_DIV    = 5'h14,
      OP_DIVU   = 5'h15,
      OP_REM    = 5'h16,
      OP_REMU   = 5'h17
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } alu_state_e;

   function automatic logic is_muldiv(input logic [4:0] op);
      return op[4:3] == 2'b10;
   endfunction

   function automatic logic is_mul(input logic [4:0] op);
      return is_muldiv(op) && !op[2];
   endfunction

   function automatic logic is_div(input logic [4:0] op);
      return is_muldiv(op) && op[2];
   endfunction

   // Multiply: only MULHU treats A as unsigned; divide: the *U forms are unsigned.
   function automatic logic is_signed_a(input logic [4:0] op);
      return is_muldiv(op) && (op[2] ? !op[0] : (op[1:0] != 2'b11));
   endfunction

   function automatic logic is_signed_b(input logic [4:0] op);
      return is_muldiv(op) && (op[2] ? !op[0] : !op[1]);
   endfunction

endpackage

// File: rtl/iterative_alu_if.sv
// Request/response bundle between the EX-stage issue logic and the iterative ALU.
interface iterative_alu_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      alu_op;
   logic [XLEN-1:0] src_A;
   logic [XLEN-1:0] src_B;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;
   logic            busy;

   modport master (
      output in_valid, alu_op, src_A, src_B, flush, out_ready,
      input  in_ready, out_valid, alu_result, alu_zero, busy
   );

   modport slave (
      input  in_valid, alu_op, src_A, src_B, flush, out_ready,
      output in_ready, out_valid, alu_result, alu_zero, busy
   );
endinterface

// File: rtl/iter_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; quotient/remainder are
// presented combinationally in the cycle that done is high.
module iter_divider #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);
   localparam int CNT_W = $clog2(XLEN);

   logic             run_q;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]  quo_q, rem_q, dvs_q;
   logic [XLEN:0]    shifted, trial;
   logic             ge;

   // The dividend shifts out of quo_q's MSB while quotient bits shift into its LSB.
   assign shifted   = {rem_q, quo_q[XLEN-1]};
   assign trial     = shifted - {1'b0, dvs_q};
   assign ge        = !trial[XLEN];
   assign remainder = ge ? trial[XLEN-1:0] : shifted[XLEN-1:0];
   assign quotient  = {quo_q[XLEN-2:0], ge};
   assign done      = run_q && (cnt_q == CNT_W'(XLEN-1));

   always_ff @(posedge clk) begin
      if (reset) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
      end else if (abort) begin
         run_q <= 1'b0;
         cnt_q <= '0;
      end else if (start) begin
         run_q <= 1'b1;
         cnt_q <= '0;
         quo_q <= dividend;
         rem_q <= '0;
         dvs_q <= divisor;
      end else if (run_q) begin
         quo_q <= quotient;
         rem_q <= remainder;
         cnt_q <= cnt_q + CNT_W'(1);
         if (done) run_q <= 1'b0;
      end
   end
endmodule

// File: rtl/iterative_alu.sv
// RV32I/M execute unit: single-cycle ALU ops, iterative multiply and divide.
// Define ALU_FAST_MUL_EN to replace the iterative multiplier with a combinational one.
module iterative_alu
   import alu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input logic            clk,
   input logic            reset,
   iterative_alu_if.slave bus
);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   alu_state_e      state_q, state_d;
   logic [4:0]      op_q;
   logic [XLEN-1:0] res_q, accept_res, abs_a, abs_b, quo, rem, div_res, mul_res;
   logic            accept, neg_a, neg_b, div_special, div_start, div_done;
   logic            neg_q_q, neg_r_q, mul_last, mul_iter;

   function automatic logic [XLEN-1:0] alu_single(input logic [4:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
      logic signed [XLEN-1:0] a_s, b_s;
      logic [SHAMT_W-1:0]     sh;
      a_s = a;
      b_s = b;
      sh  = b[SHAMT_W-1:0];
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SLT:  return XLEN'(a_s < b_s);
         OP_SLTU: return XLEN'(a < b);
         OP_SLL:  return a << sh;
         OP_SRL:  return a >> sh;
         OP_SRA:  return a_s >>> sh;
         OP_ABJ:  return a & ~b;
         default: return '0;
      endcase
   endfunction

   assign accept      = (state_q == S_IDLE) && bus.in_valid && !bus.flush;
   assign neg_a       = is_signed_a(bus.alu_op) && bus.src_A[XLEN-1];
   assign neg_b       = is_signed_b(bus.alu_op) && bus.src_B[XLEN-1];
   assign abs_a       = neg_a ? -bus.src_A : bus.src_A;
   assign abs_b       = neg_b ? -bus.src_B : bus.src_B;
   assign div_special = (bus.src_B == '0) ||
                        (is_signed_a(bus.alu_op) && bus.src_A == MIN_NEG && bus.src_B == '1);
   assign div_start   = accept && is_div(bus.alu_op) && !div_special;

   iter_divider #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (div_start),
      .abort     (bus.flush),
      .dividend  (abs_a),
      .divisor   (abs_b),
      .done      (div_done),
      .quotient  (quo),
      .remainder (rem)
   );

   // op_q[1] distinguishes REM* from DIV*.
   assign div_res = op_q[1] ? (neg_r_q ? -rem : rem) : (neg_q_q ? -quo : quo);

`ifdef ALU_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   assign fast_prod = {{XLEN{neg_a}}, bus.src_A} * {{XLEN{neg_b}}, bus.src_B};
   assign mul_res   = (bus.alu_op[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
   assign mul_last  = 1'b0;
   assign mul_iter  = 1'b0;
`else
   logic [XLEN-1:0]    mcand_q;
   logic [2*XLEN-1:0]  prod_q, prod_nx, prod_fix;
   logic [XLEN:0]      mul_sum;
   logic [SHAMT_W-1:0] cnt_q;
   logic               neg_p_q;

   // Shift-add on magnitudes: upper half accumulates, multiplier drains from the low half.
   assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
   assign prod_nx  = {mul_sum, prod_q[XLEN-1:1]};
   assign prod_fix = neg_p_q ? -prod_nx : prod_nx;
   assign mul_res  = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
   assign mul_last = (cnt_q == SHAMT_W'(XLEN-1));
   assign mul_iter = 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         neg_p_q <= 1'b0;
      end else if (accept) begin
         mcand_q <= abs_a;
         prod_q  <= {{XLEN{1'b0}}, abs_b};
         cnt_q   <= '0;
         neg_p_q <= neg_a ^ neg_b;
      end else if (state_q == S_MUL) begin
         prod_q <= prod_nx;
         cnt_q  <= cnt_q + SHAMT_W'(1);
      end
   end
`endif

   always_comb begin
      accept_res = alu_single(bus.alu_op, bus.src_A, bus.src_B);
      if (is_div(bus.alu_op)) begin
         if (bus.src_B == '0) accept_res = bus.alu_op[1] ? bus.src_A : '1;
         else                 accept_res = bus.alu_op[1] ? '0 : bus.src_A;
      end
      if (is_mul(bus.alu_op) && !mul_iter) accept_res = mul_res;
   end

   always_comb begin
      state_d = state_q;
      if (bus.flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (bus.in_valid) begin
               if (is_mul(bus.alu_op) && mul_iter)             state_d = S_MUL;
               else if (is_div(bus.alu_op) && !div_special)    state_d = S_DIV;
               else                                            state_d = S_DONE;
            end
            S_MUL:   if (mul_last)      state_d = S_DONE;
            S_DIV:   if (div_done)      state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         res_q   <= '0;
         op_q    <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
      end else if (accept) begin
         res_q   <= accept_res;
         op_q    <= bus.alu_op;
         neg_q_q <= neg_a ^ neg_b;
         neg_r_q <= neg_a;
      end else if (!bus.flush && state_q == S_MUL && mul_last) begin
         res_q <= mul_res;
      end else if (!bus.flush && state_q == S_DIV && div_done) begin
         res_q <= div_res;
      end
   end

   assign bus.in_ready   = (state_q == S_IDLE) && !reset;
   assign bus.out_valid  = (state_q == S_DONE);
   assign bus.alu_result = res_q;
   assign bus.alu_zero   = (res_q == '0);
   assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_iterative_alu.sv
// Directed bench for iterative_alu: vector table plus backpressure, flush and reset sequences.
module tb_iterative_alu;
   import alu_pkg::*;

   localparam int XLEN = 32;
`ifdef ALU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = XLEN + 1;
`endif
   localparam int DIV_LAT = XLEN + 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   iterative_alu_if #(.XLEN(XLEN)) bus ();
   iterative_alu #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      string       name;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string name, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int lat);
      vec_t v;
      v.name = name; v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   // Offer one op with out_ready=1; returns result, zero flag and accept-to-out_valid latency.
   task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic zero, output int lat);
      bus.in_valid  = 1'b1;
      bus.alu_op    = op;
      bus.src_A     = a;
      bus.src_B     = b;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.alu_op   = OP_ADD;
      bus.src_A    = 32'hDEADBEEF;
      bus.src_B    = 32'h00001234;
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      res  = bus.alu_result;
      zero = bus.alu_zero;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] res;
      logic        zero;
      int          lat;
      int          seen;

      bus.in_valid  = 1'b0;
      bus.alu_op    = OP_ADD;
      bus.src_A     = '0;
      bus.src_B     = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;

      @(negedge clk);
      check("in_ready during reset", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset in_ready", 32'(bus.in_ready), 32'd1);
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset alu_result", bus.alu_result, 32'd0);
      check("reset alu_zero", 32'(bus.alu_zero), 32'd1);
      check("reset busy", 32'(bus.busy), 32'd0);

      add("ADD wrap",      OP_ADD,    32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
      add("SUB",           OP_SUB,    32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1);
      add("AND",           OP_AND,    32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1);
      add("OR",            OP_OR,     32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1);
      add("XOR",           OP_XOR,    32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
      add("SLT",           OP_SLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
      add("SLTU",          OP_SLTU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
      add("SLL shamt mask",OP_SLL,    32'h00000001, 32'h00000021, 32'h00000002, 1);
      add("SRL",           OP_SRL,    32'h80000000, 32'h00000024, 32'h08000000, 1);
      add("SRA",           OP_SRA,    32'h80000000, 32'h00000024, 32'hF8000000, 1);
      add("ABJ",           OP_ABJ,    32'hFF00FF00, 32'hF0F0F0F0, 32'h0F000F00, 1);
      add("NOP",           OP_NOP,    32'h00000005, 32'h00000006, 32'h00000000, 1);
      add("undef 0x0C",    5'h0C,     32'h00000005, 32'h00000006, 32'h00000000, 1);
      add("undef 0x1F",    5'h1F,     32'h00000005, 32'h00000006, 32'h00000000, 1);
      add("MUL",           OP_MUL,    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, MUL_LAT);
      add("MULH",          OP_MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT);
      add("MULHU",         OP_MULHU,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, MUL_LAT);
      add("MULHSU pos",    OP_MULHSU, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, MUL_LAT);
      add("MULHSU neg",    OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
      add("MULHU max",     OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
      add("MULH minmin",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
      add("DIV -7/2",      OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT);
      add("REM -7/2",      OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_LAT);
      add("DIV 7/-2",      OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT);
      add("REM 7/-2",      OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, DIV_LAT);
      add("DIVU 100/7",    OP_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, DIV_LAT);
      add("REMU 100/7",    OP_REMU,   32'h00000064, 32'h00000007, 32'h00000002, DIV_LAT);
      add("DIVU max/1",    OP_DIVU,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, DIV_LAT);
      add("DIVU min/-1",   OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, DIV_LAT);
      add("DIVU by 0",     OP_DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1);
      add("REMU by 0",     OP_REMU,   32'h00000005, 32'h00000000, 32'h00000005, 1);
      add("DIV by 0",      OP_DIV,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1);
      add("REM by 0",      OP_REM,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1);
      add("DIV overflow",  OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      add("REM overflow",  OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         check({vecs[i].name, " in_ready"}, 32'(bus.in_ready), 32'd1);
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, zero, lat);
         check(vecs[i].name, res, vecs[i].exp);
         check({vecs[i].name, " zero"}, 32'(zero), 32'(vecs[i].exp == 32'd0));
         check({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
      end

      // Backpressure: DIVU 100/7 held in DONE for 5 cycles.
      bus.in_valid  = 1'b1;
      bus.alu_op    = OP_DIVU;
      bus.src_A     = 32'd100;
      bus.src_B     = 32'd7;
      bus.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.src_A    = '0;
      bus.src_B    = '0;
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         check("bp in_ready while busy", 32'(bus.in_ready), 32'd0);
         @(negedge clk);
         lat++;
      end
      check("bp latency", 32'(lat), 32'(DIV_LAT));
      for (int k = 0; k < 5; k++) begin
         check("bp result held", bus.alu_result, 32'd14);
         check("bp out_valid held", 32'(bus.out_valid), 32'd1);
         check("bp in_ready low", 32'(bus.in_ready), 32'd0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp release out_valid", 32'(bus.out_valid), 32'd0);
      check("bp release in_ready", 32'(bus.in_ready), 32'd1);

      // Flush a DIV around cycle 10 while an ADD is already being offered.
      bus.in_valid = 1'b1;
      bus.alu_op   = OP_DIV;
      bus.src_A    = 32'hFFFFFFF9;
      bus.src_B    = 32'd2;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         if (bus.out_valid) seen++;
         @(negedge clk);
      end
      check("flush busy before", 32'(bus.busy), 32'd1);
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.alu_op   = OP_ADD;
      bus.src_A    = 32'd3;
      bus.src_B    = 32'd4;
      @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush out_valid", 32'(bus.out_valid), 32'd0);
      check("flush not accepted", 32'(bus.busy), 32'd0);
      check("flush in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("post-flush ADD valid", 32'(bus.out_valid), 32'd1);
      check("post-flush ADD result", bus.alu_result, 32'd7);
      @(negedge clk);
      for (int k = 0; k < XLEN + 4; k++) begin
         if (bus.out_valid) seen++;
         @(negedge clk);
      end
      check("flushed DIV never valid", 32'(seen), 32'd0);

      // Reset in the middle of a multiply.
      bus.in_valid = 1'b1;
      bus.alu_op   = OP_MULH;
      bus.src_A    = 32'hFFFFFFFF;
      bus.src_B    = 32'd2;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid-mul reset in_ready", 32'(bus.in_ready), 32'd0);
      check("mid-mul reset out_valid", 32'(bus.out_valid), 32'd0);
      check("mid-mul reset result", bus.alu_result, 32'd0);
      check("mid-mul reset zero", 32'(bus.alu_zero), 32'd1);
      check("mid-mul reset busy", 32'(bus.busy), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("after reset in_ready", 32'(bus.in_ready), 32'd1);
      do_op(OP_MULHU, 32'hFFFFFFFF, 32'd2, res, zero, lat);
      check("after reset MULHU", res, 32'd1);
      check("after reset MULHU latency", 32'(lat), 32'(MUL_LAT));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
